// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with a three-state fetch FSM, a one-entry skid buffer and the IF/ID register
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc_out,
   input  logic [31:0] pc_plus4_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic [31:0] fetch_count
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
   state_t state, state_nxt;
   logic [31:0] pc, buf_instr, buf_pc4;
   logic accept;
   assign accept = imem_req & imem_ack;
   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nxt;
   // next-state: redirect and flush both restart fetching; an accept under stall parks in HOLD
   always_comb begin
      state_nxt = FETCH;
      if (!redirect_valid && !flush)
         state_nxt = state == FETCH ? (accept && stall ? HOLD : FETCH) :
                     state == HOLD  ? (stall ? HOLD : FETCH) : FETCH;
   end
   // outputs: request only while fetching and not being redirected or flushed
   always_comb begin
      imem_req  = state == FETCH && !redirect_valid && !flush;
      imem_addr = pc;
      pc_out    = pc;
   end
   // datapath: pc, skid buffer, IF/ID register and accepted-instruction counter
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC & 32'hFFFF_FFFC;
         buf_instr   <= '0;
         buf_pc4     <= '0;
         ifid_valid  <= 1'b0;
         ifid_instr  <= '0;
         ifid_pc4    <= '0;
         fetch_count <= '0;
      end else if (redirect_valid) begin
         pc         <= redirect_pc & 32'hFFFF_FFFC;
         ifid_valid <= 1'b0;
      end else if (flush) begin
         ifid_valid <= 1'b0;
      end else if (state == FETCH) begin
         if (accept) begin
            pc          <= pc_plus4_in;
            fetch_count <= fetch_count + 32'd1;
            if (stall) begin
               buf_instr <= imem_rdata;
               buf_pc4   <= pc_plus4_in;
            end else begin
               ifid_valid <= 1'b1;
               ifid_instr <= imem_rdata;
               ifid_pc4   <= pc_plus4_in;
            end
         end else if (!stall) begin
            ifid_valid <= 1'b0;
         end
      end else if (state == HOLD && !stall) begin
         ifid_valid <= 1'b1;
         ifid_instr <= buf_instr;
         ifid_pc4   <= buf_pc4;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch, skid hold, redirect, flush and PC wrap
module tb_fetch_stage;
   logic clk = 0;
   logic rst = 1, rst2 = 1;
   logic imem_ack = 0, imem_ack2 = 0;
   logic stall = 0, flush = 0, redirect_valid = 0;
   logic [31:0] redirect_pc = '0;
   logic zero = 0;
   logic [31:0] zero32 = '0;
   logic [31:0] pc_out, imem_addr, ifid_instr, ifid_pc4, fetch_count, pc_plus4_in, imem_rdata;
   logic imem_req, ifid_valid;
   logic [31:0] pc_out2, imem_addr2, ifid_instr2, ifid_pc42, fetch_count2, pc_plus4_in2, imem_rdata2;
   logic imem_req2, ifid_valid2;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;
   assign pc_plus4_in  = pc_out + 32'd4;
   assign imem_rdata   = imem_addr;
   assign pc_plus4_in2 = pc_out2 + 32'd4;
   assign imem_rdata2  = imem_addr2;

   fetch_stage dut (
      .clk(clk), .rst(rst), .pc_out(pc_out), .pc_plus4_in(pc_plus4_in),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .fetch_count(fetch_count));

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .rst(rst2), .pc_out(pc_out2), .pc_plus4_in(pc_plus4_in2),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
      .stall(zero), .flush(zero), .redirect_valid(zero), .redirect_pc(zero32),
      .ifid_valid(ifid_valid2), .ifid_instr(ifid_instr2), .ifid_pc4(ifid_pc42), .fetch_count(fetch_count2));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; imem_ack = 0;
      cyc();
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc_out, 32'h0); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", ifid_valid); end
      checks++; if (ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin errors++; $display("FAIL reset_ifid: got %h/%h exp 0/0", ifid_instr, ifid_pc4); end
      checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h exp 0", fetch_count); end
      rst = 0;
   endtask

   task automatic test_stream();
      imem_ack = 1;
      cyc();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b exp 0", ifid_valid); end
      cyc();
      checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h4) begin errors++; $display("FAIL stream_0: got v=%b i=%h p=%h exp v=1 i=0 p=4", ifid_valid, ifid_instr, ifid_pc4); end
      for (int k = 1; k <= 3; k++) begin
         cyc();
         checks++; if (ifid_instr !== 32'(4*k) || imem_addr !== 32'(4*k+4) || fetch_count !== 32'(k+1)) begin
            errors++; $display("FAIL stream_%0d: got i=%h a=%h c=%0d exp i=%h a=%h c=%0d", k, ifid_instr, imem_addr, fetch_count, 4*k, 4*k+4, k+1);
         end
      end
   endtask

   task automatic test_hold();
      rst = 1; imem_ack = 0;
      cyc();
      rst = 0; imem_ack = 1;
      cyc(); cyc(); cyc();
      checks++; if (imem_addr !== 32'h8 || ifid_instr !== 32'h4) begin errors++; $display("FAIL hold_setup: got a=%h i=%h exp a=8 i=4", imem_addr, ifid_instr); end
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++; if (imem_req !== 1'b0 || pc_out !== 32'hC || ifid_instr !== 32'h4 || ifid_valid !== 1'b1 || fetch_count !== 32'd3) begin
            errors++; $display("FAIL hold_%0d: got req=%b pc=%h i=%h v=%b c=%0d exp req=0 pc=c i=4 v=1 c=3", k, imem_req, pc_out, ifid_instr, ifid_valid, fetch_count);
         end
      end
      stall = 0;
      cyc();
      checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h8 || ifid_pc4 !== 32'hC) begin errors++; $display("FAIL hold_release: got v=%b i=%h p=%h exp v=1 i=8 p=c", ifid_valid, ifid_instr, ifid_pc4); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || fetch_count !== 32'd3) begin errors++; $display("FAIL hold_next_req: got req=%b a=%h c=%0d exp req=1 a=c c=3", imem_req, imem_addr, fetch_count); end
   endtask

   task automatic test_bubble();
      imem_ack = 0;
      cyc();
      checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'hC || ifid_instr !== 32'h8 || fetch_count !== 32'd3) begin
         errors++; $display("FAIL bubble: got v=%b a=%h i=%h c=%0d exp v=0 a=c i=8 c=3", ifid_valid, imem_addr, ifid_instr, fetch_count);
      end
   endtask

   task automatic test_redirect();
      imem_ack = 1; redirect_valid = 1; redirect_pc = 32'h0000_0103;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redirect_req: got %b exp 0", imem_req); end
      cyc();
      checks++; if (pc_out !== 32'h100 || ifid_valid !== 1'b0 || fetch_count !== 32'd3) begin
         errors++; $display("FAIL redirect: got pc=%h v=%b c=%0d exp pc=100 v=0 c=3", pc_out, ifid_valid, fetch_count);
      end
      redirect_valid = 0;
      cyc();
      checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h100 || ifid_pc4 !== 32'h104 || fetch_count !== 32'd4) begin
         errors++; $display("FAIL redirect_target: got v=%b i=%h p=%h c=%0d exp v=1 i=100 p=104 c=4", ifid_valid, ifid_instr, ifid_pc4, fetch_count);
      end
   endtask

   task automatic test_flush();
      stall = 1;
      cyc();
      checks++; if (pc_out !== 32'h108 || imem_req !== 1'b0 || ifid_instr !== 32'h100 || fetch_count !== 32'd5) begin
         errors++; $display("FAIL flush_setup: got pc=%h req=%b i=%h c=%0d exp pc=108 req=0 i=100 c=5", pc_out, imem_req, ifid_instr, fetch_count);
      end
      flush = 1;
      cyc();
      checks++; if (ifid_valid !== 1'b0 || pc_out !== 32'h108 || ifid_instr !== 32'h100) begin
         errors++; $display("FAIL flush_hold: got v=%b pc=%h i=%h exp v=0 pc=108 i=100", ifid_valid, pc_out, ifid_instr);
      end
      flush = 0; stall = 0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin errors++; $display("FAIL flush_refetch: got req=%b a=%h exp req=1 a=108", imem_req, imem_addr); end
      cyc();
      checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h108 || fetch_count !== 32'd6) begin
         errors++; $display("FAIL flush_after: got v=%b i=%h c=%0d exp v=1 i=108 c=6", ifid_valid, ifid_instr, fetch_count);
      end
   endtask

   task automatic test_wrap();
      rst2 = 1; imem_ack2 = 0;
      cyc();
      checks++; if (pc_out2 !== 32'hFFFF_FFF8 || imem_req2 !== 1'b0) begin errors++; $display("FAIL wrap_reset: got pc=%h req=%b exp pc=fffffff8 req=0", pc_out2, imem_req2); end
      rst2 = 0; imem_ack2 = 1;
      cyc();
      checks++; if (imem_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_a0: got %h exp fffffff8", imem_addr2); end
      cyc();
      checks++; if (imem_addr2 !== 32'hFFFF_FFFC || ifid_instr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_a1: got a=%h i=%h exp a=fffffffc i=fffffff8", imem_addr2, ifid_instr2); end
      cyc();
      checks++; if (imem_addr2 !== 32'h0 || ifid_pc42 !== 32'h0 || fetch_count2 !== 32'd2) begin errors++; $display("FAIL wrap_a2: got a=%h p=%h c=%0d exp a=0 p=0 c=2", imem_addr2, ifid_pc42, fetch_count2); end
      imem_ack2 = 0;
      cyc();
      rst2 = 1;
      cyc();
      checks++; if (pc_out2 !== 32'hFFFF_FFF8 || ifid_valid2 !== 1'b0 || fetch_count2 !== 32'd0 || imem_req2 !== 1'b0 || ifid_instr2 !== 32'h0) begin
         errors++; $display("FAIL wrap_midreset: got pc=%h v=%b c=%0d req=%b i=%h exp pc=fffffff8 v=0 c=0 req=0 i=0", pc_out2, ifid_valid2, fetch_count2, imem_req2, ifid_instr2);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_hold();
      test_bubble();
      test_redirect();
      test_flush();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pc_out  output  32  current fetch PC; drives Adder input A (B tied to 32'd4 outside this block).
REQ-005 pc_plus4_in  input  32  Adder output (pc_out + 4).
REQ-006 imem_req  output  1  instruction-memory request, level.
REQ-007 imem_addr  output  32  request address, equal to pc_out.
REQ-008 imem_ack  input  1  read data valid this cycle; meaningful only while imem_req=1.
REQ-009 imem_rdata  input  32  instruction word, sampled when imem_req&imem_ack.
REQ-010 stall  input  1  hazard unit hold of IF/ID.
REQ-011 flush  input  1  invalidate IF/ID and buffered instruction.
REQ-012 redirect_valid  input  1  branch/jump taken.
REQ-013 redirect_pc  input  32  branch/jump target.
REQ-014 ifid_valid  output  1  IF/ID holds a live instruction.
REQ-015 ifid_instr  output  32  IF/ID instruction.
REQ-016 ifid_pc4  output  32  IF/ID PC+4.
REQ-017 fetch_count  output  32  count of instructions accepted from memory.

Function
REQ-018 FSM states: IDLE, FETCH, HOLD; IDLE lasts exactly one cycle, then FETCH.
REQ-019 imem_req SHALL be 1 only in FETCH with redirect_valid=0 and flush=0; 0 in IDLE and HOLD.
REQ-020 FETCH, ack, stall=0: ifid <= {1, imem_rdata, pc_plus4_in}; pc <= pc_plus4_in; stay FETCH.
REQ-021 FETCH, ack, stall=1: skid buffer <= {imem_rdata, pc_plus4_in}; pc <= pc_plus4_in; IF/ID unchanged; go HOLD.
REQ-022 FETCH, no ack: pc and imem_addr held; stall=0 -> ifid_valid <= 0 (bubble); stall=1 -> IF/ID unchanged.
REQ-023 HOLD, stall=0: ifid <= {1, buffer}; go FETCH; HOLD, stall=1: remain, all state held.
REQ-024 Latency: instruction acked in cycle N with stall=0 visible on ifid_* in cycle N+1.
REQ-025 redirect_valid=1 (any state): pc <= {redirect_pc[31:2], 2'b00}; ifid_valid <= 0; buffer discarded; next state FETCH; any same-cycle ack ignored.
REQ-026 flush=1, redirect_valid=0: ifid_valid <= 0; buffer discarded; pc unchanged; next state FETCH; same-cycle ack ignored.
REQ-027 Priority: rst > redirect_valid > flush > stall.
REQ-028 Each instruction enters IF/ID exactly once; none dropped or duplicated absent flush/redirect.
REQ-029 fetch_count increments by 1 on every accepted ack (REQ-020/021); wraps 32'hFFFF_FFFF -> 0.
REQ-030 PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 via pc_plus4_in; no special handling.
REQ-031 ifid_instr/ifid_pc4 keep last values when ifid_valid cleared.

Reset
REQ-032 rst=1 on edge: pc_out=RESET_PC (low 2 bits forced 0), state IDLE, ifid_valid=0, ifid_instr=0, ifid_pc4=0, buffer cleared, fetch_count=0, imem_req=0.
REQ-033 rst mid-transaction (FETCH waiting ack or HOLD) aborts it; next cycle matches REQ-032.

Verification
REQ-034 Reset, ack every cycle, rdata=pc: imem_addr 0,4,8,...; ifid_instr 0,4,8 from cycle 2 after reset; fetch_count tracks.
REQ-035 Ack at addr 8 with stall=1 for 3 cycles: HOLD, imem_req=0, pc_out=12; stall drop -> ifid_instr=word@8, ifid_pc4=12, next request addr 12.
REQ-036 redirect_valid=1, redirect_pc=32'h0000_0103 with simultaneous ack: ifid_valid=0, pc_out=32'h0000_0100, fetch_count unchanged.
REQ-037 flush in HOLD with stall=1: buffer dropped, ifid_valid=0, FETCH next, pc unchanged.
REQ-038 RESET_PC=32'hFFFF_FFF8, ack every cycle: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; rst asserted mid-wait returns pc_out to FFFF_FFF8.
